rgbw_frame_decoder: RTL and testbench

Frame decoder between the SPI byte receiver and the colour generator. It consumes the receiver's byte stream (`data_byte` plus `rdy`) and assembles fixed-length command frames. It validates the sync byte and, optionally, a checksum. It then atomically commits mode, intensity, RGBW levels and colour index to registered outputs consumed by `colorGen`.

---
 rtl/rgbw_frame_decoder_if.sv | 26 ++
 rtl/rgbw_frame_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_rgbw_frame_decoder.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgbw_frame_decoder_if.sv
// ---------------------------------------------------------------------------
// rgbw_frame_decoder_if
//   Byte stream from the SPI receiver into the frame decoder.
//
//   Signals:
//     rdy        byte-ready level; a byte is taken on its rising edge
//     data_byte  received byte, stable while rdy is high
//     cs         raw SPI chip select, active low, asynchronous to clk
//
//   Handshake: there is no back-pressure. The master raises rdy with
//   data_byte stable and keeps it high for at least one clock. The slave
//   consumes exactly one byte per rising edge of rdy. rdy must then be low
//   for at least one clock before the next byte.
//
//   Modports:
//     master  drives the stream (SPI receiver / testbench)
//     slave   consumes the stream (frame decoder)
// ---------------------------------------------------------------------------
interface rgbw_frame_decoder_if;
  logic       rdy;
  logic [7:0] data_byte;
  logic       cs;

  modport master (output rdy, output data_byte, output cs);
  modport slave  (input  rdy, input  data_byte, input  cs);
endinterface

// File: rtl/rgbw_frame_decoder.sv
// ---------------------------------------------------------------------------
// rgbw_frame_decoder
//   Assembles fixed-length command frames from the SPI byte stream and
//   atomically commits mode, intensity, RGBW levels and colour index to
//   registered outputs for the colour generator.
//
//   Frame: SYNC, mode, lint, red, green, blue, white, colorIdx, [checksum]
//
//   Optional feature macro: RGBW_DEC_CHECKSUM_EN
//     defined   : 9-byte frame; trailing XOR checksum over the 7 payload
//                 bytes is checked, mismatch raises frame_err.
//     undefined : 8-byte frame; commit follows colorIdx directly and
//                 frame_err is raised only by aborts.
//
//   Ports:
//     clk            system clock
//     reset          asynchronous active-low reset
//     bus            byte stream (rdy, data_byte, cs), slave side
//     mode_sync      committed mode byte
//     lint_sync      committed global intensity
//     red/green/blue/white_sync  committed channel levels
//     colorIdx_sync  committed colour-wheel index
//     upd            one-cycle pulse when new values are committed
//     frame_err      one-cycle pulse on checksum failure or abort
//     err_cnt        saturating count of frame_err pulses
//     busy           high while a frame is in progress
//     dbg_state_o    current FSM state encoding
// ---------------------------------------------------------------------------
module rgbw_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ERR_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  rgbw_frame_decoder_if.slave bus,
  output logic [7:0]       mode_sync,
  output logic [7:0]       lint_sync,
  output logic [7:0]       red_sync,
  output logic [7:0]       green_sync,
  output logic [7:0]       blue_sync,
  output logic [7:0]       white_sync,
  output logic [7:0]       colorIdx_sync,
  output logic             upd,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'd6;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shadow_q [0:6];
  logic             shadow_we;
  logic             commit;
  logic             rdy_q;
  logic             stb;
  logic             cs_m_q, cs_s_q;
  logic             upd_q;
  logic             frame_err_q, frame_err_d;
  logic [ERR_W-1:0] err_cnt_q;
  logic [7:0]       mode_q, lint_q, red_q, green_q, blue_q, white_q, cidx_q;
`ifdef RGBW_DEC_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  // Rising-edge detect on the receiver's ready level.
  assign stb = bus.rdy & ~rdy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q  <= 1'b0;
      cs_m_q <= 1'b1;
      cs_s_q <= 1'b1;
    end else begin
      rdy_q  <= bus.rdy;
      cs_m_q <= bus.cs;
      cs_s_q <= cs_m_q;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      upd_q       <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      for (int i = 0; i < 7; i++) shadow_q[i] <= 8'h00;
`ifdef RGBW_DEC_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      upd_q       <= commit;
      frame_err_q <= frame_err_d;
      if (frame_err_d && (err_cnt_q != {ERR_W{1'b1}}))
        err_cnt_q <= err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
      if (shadow_we) shadow_q[idx_q] <= bus.data_byte;
`ifdef RGBW_DEC_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Committed outputs change only on the COMMIT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= 8'h00;
      lint_q  <= 8'h00;
      red_q   <= 8'h00;
      green_q <= 8'h00;
      blue_q  <= 8'h00;
      white_q <= 8'h00;
      cidx_q  <= 8'h00;
    end else if (commit) begin
      mode_q  <= shadow_q[0];
      lint_q  <= shadow_q[1];
      red_q   <= shadow_q[2];
      green_q <= shadow_q[3];
      blue_q  <= shadow_q[4];
      white_q <= shadow_q[5];
      cidx_q  <= shadow_q[6];
    end
  end

  // Next-state logic. Deselect (cs_s high) mid-frame wins over a byte on
  // the same edge; the partially filled shadows are simply overwritten by
  // the next frame, so nothing needs clearing.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_we   = 1'b0;
    commit      = 1'b0;
    frame_err_d = 1'b0;
`ifdef RGBW_DEC_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (stb && (bus.data_byte == SYNC_BYTE)) begin
          state_d = ST_PAYLOAD;
          idx_d   = 3'd0;
`ifdef RGBW_DEC_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      ST_PAYLOAD: begin
        if (cs_s_q) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (stb) begin
          shadow_we = 1'b1;
          idx_d     = idx_q + 3'd1;
`ifdef RGBW_DEC_CHECKSUM_EN
          csum_d    = csum_q ^ bus.data_byte;
          if (idx_q == LAST_IDX) state_d = ST_CHECK;
`else
          if (idx_q == LAST_IDX) state_d = ST_COMMIT;
`endif
        end
      end
`ifdef RGBW_DEC_CHECKSUM_EN
      ST_CHECK: begin
        if (cs_s_q) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (stb) begin
          if (bus.data_byte == csum_q) begin
            state_d = ST_COMMIT;
          end else begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
          end
        end
      end
`endif
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mode_sync     = mode_q;
  assign lint_sync     = lint_q;
  assign red_sync      = red_q;
  assign green_sync    = green_q;
  assign blue_sync     = blue_q;
  assign white_sync    = white_q;
  assign colorIdx_sync = cidx_q;
  assign upd           = upd_q;
  assign frame_err     = frame_err_q;
  assign err_cnt       = err_cnt_q;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_rgbw_frame_decoder
//   Self-checking bench for rgbw_frame_decoder. Frames are described as a
//   56-bit packed payload (byte 0 = mode ... byte 6 = colorIdx). The model
//   keeps the last committed payload and the expected error count.
//   Build with or without RGBW_DEC_CHECKSUM_EN to match the DUT.
// ---------------------------------------------------------------------------
module tb_rgbw_frame_decoder;

  localparam logic [7:0] SYNC  = 8'hA5;
  localparam int         ERR_W = 4;

  logic             clk;
  logic             reset;
  logic [7:0]       mode_sync, lint_sync, red_sync, green_sync;
  logic [7:0]       blue_sync, white_sync, colorIdx_sync;
  logic             upd, frame_err, busy;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       dbg_state;

  rgbw_frame_decoder_if bus();

  rgbw_frame_decoder #(.SYNC_BYTE(SYNC), .ERR_W(ERR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .mode_sync     (mode_sync),
    .lint_sync     (lint_sync),
    .red_sync      (red_sync),
    .green_sync    (green_sync),
    .blue_sync     (blue_sync),
    .white_sync    (white_sync),
    .colorIdx_sync (colorIdx_sync),
    .upd           (upd),
    .frame_err     (frame_err),
    .err_cnt       (err_cnt),
    .busy          (busy),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [55:0]      exp_q [$];
  logic [55:0]      exp_out;
  int               exp_err;
  int               n_checks = 0;
  int               n_pass   = 0;
  int               upd_pulses = 0;
  int               err_pulses = 0;

  always @(negedge clk) begin
    if (upd)       upd_pulses++;
    if (frame_err) err_pulses++;
  end

  function automatic logic [55:0] dut_out();
    return {colorIdx_sync, white_sync, blue_sync, green_sync,
            red_sync, lint_sync, mode_sync};
  endfunction

  function automatic logic [7:0] xor_sum(input logic [55:0] p);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 7; i++) s = s ^ p[8*i +: 8];
    return s;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  // ---------------- driver tasks ----------------
  // All drivers start and end 1 time unit after a rising clock edge.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    bus.data_byte = b;
    bus.rdy       = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus.rdy    = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends SYNC, payload and (checksum build) trailing checksum byte.
  // Last byte is followed by last_gap edges; with last_gap==1 the caller
  // lands one edge after the final stb edge.
  task automatic send_frame(input logic [55:0] p, input logic [7:0] csum_xor,
                            input bit rnd, input int last_gap);
    int h, g;
    h = rnd ? $urandom_range(1, 4) : 1;
    g = rnd ? $urandom_range(1, 3) : 1;
    send_byte(SYNC, h, g);
`ifdef RGBW_DEC_CHECKSUM_EN
    for (int i = 0; i < 7; i++) begin
      h = rnd ? $urandom_range(1, 4) : 1;
      g = rnd ? $urandom_range(1, 3) : 1;
      send_byte(p[8*i +: 8], h, g);
    end
    send_byte(xor_sum(p) ^ csum_xor, 1, last_gap);
`else
    for (int i = 0; i < 6; i++) begin
      h = rnd ? $urandom_range(1, 4) : 1;
      g = rnd ? $urandom_range(1, 3) : 1;
      send_byte(p[8*i +: 8], h, g);
    end
    send_byte(p[55:48], 1, last_gap);
    if (csum_xor != 8'h00) $display("note: checksum disabled, csum_xor ignored");
`endif
  endtask

  task automatic abort_frame(input int n_payload);
    send_byte(SYNC, 1, 1);
    for (int i = 0; i < n_payload; i++) send_byte(8'($urandom_range(0, 255)), 1, 1);
    bus.cs = 1'b1;
    idle_cycles(5);
    bus.cs = 1'b0;
    idle_cycles(3);
    exp_err = sat_inc(exp_err);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    bus.rdy = 1'b0; bus.data_byte = 8'h00; bus.cs = 1'b0;
    exp_out = '0; exp_err = 0;
    #12;
    n_checks++;
    if (dut_out() !== 56'h0) $display("FAIL reset_outputs: got %h want 0", dut_out());
    else n_pass++;
    n_checks++;
    if ({upd, frame_err, busy} !== 3'b000 || err_cnt !== 4'd0)
      $display("FAIL reset_flags: upd=%b ferr=%b busy=%b err_cnt=%0d want 0", upd, frame_err, busy, err_cnt);
    else n_pass++;
    @(posedge clk); #1 reset = 1'b1;
    idle_cycles(3);
  endtask

  task automatic test_valid_frame();
    logic [55:0] p = {8'h05, 8'h40, 8'h30, 8'h20, 8'h10, 8'h80, 8'h01};
    int u0 = upd_pulses;
    send_frame(p, 8'h00, 1'b0, 1);
    exp_out = p;
    n_checks++;
    if (upd !== 1'b1) $display("FAIL valid_upd_latency: upd=%b want 1", upd);
    else n_pass++;
    n_checks++;
    if (dut_out() !== exp_out) $display("FAIL valid_outputs: got %h want %h", dut_out(), exp_out);
    else n_pass++;
    idle_cycles(1);
    n_checks++;
    if (upd !== 1'b0) $display("FAIL valid_upd_width: upd=%b want 0", upd);
    else n_pass++;
    idle_cycles(2);
    n_checks++;
    if (upd_pulses - u0 !== 1 || err_cnt !== exp_err[ERR_W-1:0] || busy !== 1'b0)
      $display("FAIL valid_counts: upd_pulses=%0d want 1 err_cnt=%0d want %0d busy=%b",
               upd_pulses - u0, err_cnt, exp_err, busy);
    else n_pass++;
  endtask

`ifdef RGBW_DEC_CHECKSUM_EN
  task automatic test_bad_checksum();
    logic [55:0] p = {8'h05, 8'h40, 8'h30, 8'h20, 8'h10, 8'h80, 8'h01};
    int u0 = upd_pulses;
    int e0 = err_pulses;
    // Checksum byte 0x00 against a true sum of 0xC4.
    send_frame(p, xor_sum(p), 1'b0, 0);
    exp_err = sat_inc(exp_err);
    n_checks++;
    if (frame_err !== 1'b1) $display("FAIL csum_err_timing: frame_err=%b want 1", frame_err);
    else n_pass++;
    idle_cycles(3);
    n_checks++;
    if (err_pulses - e0 !== 1 || upd_pulses !== u0 || err_cnt !== exp_err[ERR_W-1:0])
      $display("FAIL csum_err_counts: err_pulses=%0d want 1 upd_pulses=%0d want 0 err_cnt=%0d want %0d",
               err_pulses - e0, upd_pulses - u0, err_cnt, exp_err);
    else n_pass++;
    n_checks++;
    if (dut_out() !== exp_out) $display("FAIL csum_err_hold: got %h want %h", dut_out(), exp_out);
    else n_pass++;
  endtask
`endif

  task automatic test_leading_junk();
    logic [55:0] p = {$urandom, $urandom};
    int u0 = upd_pulses;
    send_byte(8'h3C, 1, 1);
    send_byte(8'hFF, 1, 1);
    send_frame(p, 8'h00, 1'b0, 1);
    exp_q.push_back(p);
    idle_cycles(2);
    exp_out = exp_q.pop_front();
    n_checks++;
    if (dut_out() !== exp_out || upd_pulses - u0 !== 1 || err_cnt !== exp_err[ERR_W-1:0])
      $display("FAIL junk_then_frame: out=%h want %h upd=%0d want 1 err_cnt=%0d want %0d",
               dut_out(), exp_out, upd_pulses - u0, err_cnt, exp_err);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [55:0] p = {$urandom, $urandom};
    int e0 = err_pulses;
    int u0 = upd_pulses;
    send_byte(SYNC, 1, 1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1, 1);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL abort_busy_before: busy=%b want 1", busy);
    else n_pass++;
    bus.cs = 1'b1;
    idle_cycles(5);
    exp_err = sat_inc(exp_err);
    n_checks++;
    if (err_pulses - e0 !== 1 || busy !== 1'b0 || err_cnt !== exp_err[ERR_W-1:0] || dut_out() !== exp_out)
      $display("FAIL abort_effect: err_pulses=%0d want 1 busy=%b want 0 err_cnt=%0d want %0d out=%h want %h",
               err_pulses - e0, busy, err_cnt, exp_err, dut_out(), exp_out);
    else n_pass++;
    bus.cs = 1'b0;
    idle_cycles(3);
    send_frame(p, 8'h00, 1'b0, 1);
    exp_out = p;
    idle_cycles(2);
    n_checks++;
    if (dut_out() !== exp_out || upd_pulses - u0 !== 1)
      $display("FAIL abort_recover: out=%h want %h upd=%0d want 1", dut_out(), exp_out, upd_pulses - u0);
    else n_pass++;
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 12; n++) begin
      logic [55:0] p = {$urandom, $urandom};
      logic [7:0]  bad = 8'h00;
      int          nj = $urandom_range(0, 2);
      int          u0 = upd_pulses;
      logic [7:0]  j;
      for (int k = 0; k < nj; k++) begin
        j = 8'($urandom_range(0, 255));
        if (j == SYNC) j = 8'h3C;
        send_byte(j, $urandom_range(1, 3), $urandom_range(1, 3));
      end
`ifdef RGBW_DEC_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) bad = 8'($urandom_range(1, 255));
`endif
      send_frame(p, bad, 1'b1, 1);
      if (bad == 8'h00) exp_q.push_back(p);
      else exp_err = sat_inc(exp_err);
      idle_cycles(2);
      if (bad == 8'h00) exp_out = exp_q.pop_front();
      n_checks++;
      if (dut_out() !== exp_out || err_cnt !== exp_err[ERR_W-1:0] ||
          upd_pulses - u0 !== ((bad == 8'h00) ? 1 : 0))
        $display("FAIL random_frame_%0d: out=%h want %h err_cnt=%0d want %0d upd=%0d",
                 n, dut_out(), exp_out, err_cnt, exp_err, upd_pulses - u0);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [55:0] p1 = {$urandom, $urandom};
    logic [55:0] p2 = {$urandom, $urandom};
    int u0 = upd_pulses;
    send_frame(p1, 8'h00, 1'b0, 1);
    n_checks++;
    if (dut_out() !== p1) $display("FAIL b2b_first: got %h want %h", dut_out(), p1);
    else n_pass++;
    send_frame(p2, 8'h00, 1'b0, 1);
    exp_out = p2;
    idle_cycles(2);
    n_checks++;
    if (dut_out() !== exp_out || upd_pulses - u0 !== 2)
      $display("FAIL b2b_second: got %h want %h upd=%0d want 2", dut_out(), exp_out, upd_pulses - u0);
    else n_pass++;
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 20; n++) abort_frame(2);
    n_checks++;
    if (err_cnt !== exp_err[ERR_W-1:0] || exp_err != 15)
      $display("FAIL err_saturate: err_cnt=%0d want %0d", err_cnt, exp_err);
    else n_pass++;
    n_checks++;
    if (dut_out() !== exp_out) $display("FAIL saturate_hold: got %h want %h", dut_out(), exp_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [55:0] p = {$urandom, $urandom};
    send_byte(SYNC, 1, 1);
    send_byte(8'h11, 1, 1);
    send_byte(8'h22, 1, 1);
    reset = 1'b0;
    #1;
    exp_out = '0; exp_err = 0;
    n_checks++;
    if (dut_out() !== 56'h0 || busy !== 1'b0 || err_cnt !== 4'd0)
      $display("FAIL reset_mid: out=%h busy=%b err_cnt=%0d want all 0", dut_out(), busy, err_cnt);
    else n_pass++;
    @(posedge clk); #1 reset = 1'b1;
    idle_cycles(3);
    send_frame(p, 8'h00, 1'b0, 1);
    exp_out = p;
    idle_cycles(2);
    n_checks++;
    if (dut_out() !== exp_out || err_cnt !== 4'd0)
      $display("FAIL reset_recover: out=%h want %h err_cnt=%0d", dut_out(), exp_out, err_cnt);
    else n_pass++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_valid_frame();
`ifdef RGBW_DEC_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_leading_junk();
    test_abort();
    test_random_frames();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();
    if (exp_q.size() != 0) $display("note: %0d expected frames left", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
